// File: rtl/shifter.sv
// Logical barrel shifter for the ALU datapath.
// Shifts a left or right by the unsigned amount in b and registers the
// result with a single cycle of latency. Any shift of WIDTH or more
// positions produces zero. The full value of b counts, so large amounts
// are never wrapped modulo WIDTH.
module shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  // Number of mux stages, i.e. how many low bits of b select a shift distance
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] stg [0:SW];
  logic [WIDTH-1:0] shifted;
  logic             ovf;

  // Reverse bit order so that one right-shift network can also serve left shifts
  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // A shift amount of WIDTH or more clears everything.
  // This covers a b bit set at or above the stage count. It also covers a
  // stage-only amount past the top when WIDTH is not a power of two.
  always_comb begin
    ovf = 1'b0;
    if (|b[WIDTH-1:SW]) begin
      ovf = 1'b1;
    end
    if (int'(b[SW-1:0]) >= WIDTH) begin
      ovf = 1'b1;
    end
  end

  // Right-shift mux stages
  // Stage i moves the data by 2**i when b[i] is set.
  // For a left shift, the operand is reversed going in and the result is
  // reversed coming out.
  always_comb begin
    src    = opcode ? rev(a) : a;
    stg[0] = src;
    for (int i = 0; i < SW; i++) begin
      stg[i+1] = b[i] ? (stg[i] >> (1 << i)) : stg[i];
    end
    shifted = opcode ? rev(stg[SW]) : stg[SW];
  end

  // Result register
  // Reset drops whatever result is in flight. Overflowing amounts force zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
    end else if (ovf) begin
      res <= '0;
    end else begin
      res <= shifted;
    end
  end

endmodule

// File: tb/tb_shifter.sv
// Testbench for the shifter.
// Runs directed steps followed by randomized steps. Every step is checked
// one clock later against an arithmetic reference model.
module tb_shifter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] res;

  int passCount;
  int checkCount;
  int failCount;

  shifter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .res    (res)
  );

  // Free-running clock with a 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model.
  // A left shift is multiplication by a power of two, reduced modulo 2**W.
  // A right shift is integer division by a power of two.
  function automatic logic [W-1:0] model(input logic r, input logic op,
                                         input logic [W-1:0] av,
                                         input logic [W-1:0] bv);
    longint v;
    if (r) return '0;
    if (int'(bv) >= W) return '0;
    v = longint'(av);
    if (op) v = (v * (longint'(1) << bv)) % (longint'(1) << W);
    else    v = v / (longint'(1) << bv);
    return v[W-1:0];
  endfunction

  // Drive one set of inputs, away from the active edge
  task automatic applyStimulus(input logic r, input logic op,
                               input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    rst    = r;
    opcode = op;
    a      = av;
    b      = bv;
  endtask

  // Let the next rising edge capture the inputs, then compare just after it
  task automatic checkOutput(input string tag, input logic [W-1:0] expected);
    @(posedge clk);
    #1;
    checkCount++;
    assert (res === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, res, expected);
    end
  endtask

  // Drive one step and check its result against the model
  task automatic step(input string tag, input logic r, input logic op,
                      input logic [W-1:0] av, input logic [W-1:0] bv);
    applyStimulus(r, op, av, bv);
    checkOutput(tag, model(r, op, av, bv));
  endtask

  initial begin
    logic         rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    passCount  = 0;
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    opcode     = 1'b1;
    a          = 8'd42;
    b          = 8'd1;

    // Hold reset for two cycles with live operands, then release it
    applyStimulus(1'b1, 1'b1, 8'd42, 8'd1);
    checkOutput("reset_cycle1", 8'd0);
    applyStimulus(1'b1, 1'b1, 8'd42, 8'd1);
    checkOutput("reset_cycle2", 8'd0);
    applyStimulus(1'b0, 1'b1, 8'd42, 8'd1);
    checkOutput("after_reset_shl", 8'd84);

    // Switch the opcode; the new result appears one cycle later
    applyStimulus(1'b0, 1'b0, 8'd42, 8'd1);
    checkOutput("shr_42_1", 8'd21);
    applyStimulus(1'b0, 1'b0, 8'd42, 8'd1);
    checkOutput("hold_stable", 8'd21);

    // Amounts far beyond the width
    applyStimulus(1'b0, 1'b0, 8'd42, 8'd40);
    checkOutput("shr_b40", 8'd0);
    applyStimulus(1'b0, 1'b1, 8'd42, 8'd40);
    checkOutput("shl_b40", 8'd0);

    // Boundary amounts
    applyStimulus(1'b0, 1'b1, 8'h81, 8'd0);
    checkOutput("shl_b0", 8'h81);
    applyStimulus(1'b0, 1'b0, 8'h81, 8'd0);
    checkOutput("shr_b0", 8'h81);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'd7);
    checkOutput("shl_b7", 8'h80);
    applyStimulus(1'b0, 1'b0, 8'h81, 8'd7);
    checkOutput("shr_b7", 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h81, 8'd8);
    checkOutput("shl_b8", 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h81, 8'd8);
    checkOutput("shr_b8", 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'd255);
    checkOutput("shl_b255", 8'h00);
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'd16);
    checkOutput("shr_b16", 8'h00);

    // Back-to-back operations: b sweeps 0..9, opcode alternates, a is random
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom_range(0, 255));
      step("sweep", 1'b0, (i % 2) == 0, ra, W'(i));
    end

    // Reset for one cycle mid-stream, then resume
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'd1);
    checkOutput("pre_rst_shl", 8'hFE);
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'd1);
    checkOutput("mid_rst", 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'd1);
    checkOutput("post_rst_shl", 8'hFE);
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'd1);
    checkOutput("post_rst_shr", 8'h7F);

    // Randomized traffic: mostly in-range amounts, some large, occasional reset
    for (int i = 0; i < 200; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = W'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 255));
      else                           rb = W'($urandom_range(0, 9));
      step("random", ($urandom_range(0, 19) == 0), rop, ra, rb);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
